ysyx_22040088_ifu: RTL and testbench
====================================

Name: ysyx_22040088_ifu

Overview:
- Instruction fetch unit for the multi-cycle RV64 core. It sits directly upstream of the control unit.
- Owns the architectural PC, fetches one 32-bit instruction per instruction from instruction memory over a valid/ready request plus valid response interface, and presents it to decode.
- Computes the next PC from the one-hot sel_nextpc vector produced by the control unit, together with the execute-stage compare flags.

Parameters:
- XLEN, 64, PC and target width.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address (equals pc).
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode/execute accepts instruction.
- inst  out  32  registered instruction word.
- inst_pc  out  XLEN  PC of inst.
- next_valid  in  1  execute has resolved sel_nextpc and targets this cycle.
- sel_nextpc  in  7  one-hot: [0] seq, [1] jal, [2] jalr, [3] beq, [4] bne, [5] blt/bltu, [6] bge/bgeu.
- cmp_zero  in  1  ALU result == 0 (sub, used by beq/bne).
- cmp_lt  in  1  ALU slt/sltu result bit0 (used by blt/bge family).
- br_target  in  XLEN  pc + imm (jal and branch target).
- jalr_target  in  XLEN  rs1 + imm from ALU.
- nextpc_err  out  1  one-cycle pulse: illegal sel_nextpc or misaligned target.

Behaviour:
- Reset is asynchronous and active-high (clk, rst); it is fixed as such for this block. While rst is high:
  - state = IDLE, pc = RESET_PC, inst = 32'h0000_0013 (nop), inst_pc = RESET_PC.
  - All valid outputs and nextpc_err are 0.
  - Asserting rst mid-transaction aborts it immediately. A response arriving after rst deasserts and before a new request is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD, EXEC.
  - IDLE -> REQ unconditionally, one cycle after rst deasserts.
  - REQ: imem_req_valid=1, imem_addr=pc. Go to WAIT on imem_req_valid && imem_req_ready. imem_addr must stay stable while valid is high and not accepted.
  - WAIT: imem_resp_valid is sampled only in this state; any response seen in other states is ignored. On resp_valid: inst <= imem_resp_data, inst_pc <= pc, go to HOLD. The response may arrive no earlier than the cycle after acceptance. There is no timeout.
  - HOLD: inst_valid=1. inst and inst_pc stay stable until inst_ready. Go to EXEC on inst_valid && inst_ready.
  - EXEC: wait for next_valid, which is ignored in every other state. On next_valid: pc <= npc, go to REQ.
- Next-PC selection, computed in EXEC:
  - seq: pc+4.
  - jal: br_target.
  - jalr: {jalr_target[XLEN-1:1],1'b0}.
  - beq: cmp_zero ? br_target : pc+4.
  - bne: !cmp_zero ? br_target : pc+4.
  - blt family: cmp_lt ? br_target : pc+4.
  - bge family: !cmp_lt ? br_target : pc+4.
  - pc+4 wraps modulo 2^XLEN.
- Error cases, on the next_valid cycle:
  - If sel_nextpc is zero or not one-hot, npc = pc+4 and nextpc_err=1.
  - If the selected npc[1:0] != 0, nextpc_err=1 and npc = {npc[XLEN-1:2],2'b00}.
- Minimum latency per instruction, with ready and response at earliest: REQ(1) + WAIT(1) + HOLD(1) + EXEC(1) = 4 cycles.

Decomposition:
- Shared package ysyx_22040088_pkg holds:
  - FSM state encoding.
  - SEL_NEXTPC bit index constants, shared with the control unit.
  - NOP_INST and RESET_PC default.
- One natural sub-module, ysyx_22040088_nextpc: combinational npc selection, one-hot check and alignment check. The FSM and registers remain in the top.

Test Plan:
- Reset release with imem_req_ready=1 and 1-cycle response 32'h00000093 -> imem_addr=0x8000_0000 in the 2nd cycle after rst falls; inst_valid high with inst=0x00000093 and inst_pc=0x8000_0000 two cycles later.
- Seq flow: sel_nextpc=7'b0000001 with next_valid -> next request at 0x8000_0004. Repeat to pc=64'hFFFF_FFFF_FFFF_FFFC -> next address 0 (wrap).
- Branches with br_target=0x8000_0100:
  - beq, cmp_zero=1 -> pc=0x8000_0100.
  - bne, cmp_zero=1 -> pc+4.
  - bge, cmp_lt=0 -> 0x8000_0100.
  - bltu, cmp_lt=0 -> pc+4.
- Stalls: hold imem_req_ready=0 for 3 cycles, then response latency 5, then inst_ready=0 for 4 cycles -> addr and inst stable throughout; no duplicate fetch; stray imem_resp_valid in REQ/EXEC ignored.
- jalr_target=0x8000_0203 -> nextpc_err pulse, pc=0x8000_0200. sel_nextpc=7'b0000110 -> nextpc_err, pc+4.
- Assert rst in the middle of WAIT -> outputs reset asynchronously the same cycle; after release, fetch restarts at RESET_PC and a late response is ignored.

Source files
------------

// File: rtl/ysyx_22040088_pkg.sv
// Shared definitions for the ysyx_22040088 fetch path.
// Contents:
//   state_e           - fetch FSM state encoding
//   SEL_*             - bit positions of the one-hot sel_nextpc vector (shared with control unit)
//   NOP_INST          - instruction word presented after reset (addi x0, x0, 0)
//   RESET_PC_DEFAULT  - default architectural reset PC
package ysyx_22040088_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StExec
  } state_e;

  localparam int unsigned SEL_W   = 7;
  localparam int unsigned SEL_SEQ = 0;
  localparam int unsigned SEL_JAL = 1;
  localparam int unsigned SEL_JALR = 2;
  localparam int unsigned SEL_BEQ = 3;
  localparam int unsigned SEL_BNE = 4;
  localparam int unsigned SEL_BLT = 5;
  localparam int unsigned SEL_BGE = 6;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040088_nextpc.sv
// Combinational next-PC selection.
// Ports:
//   pc           - current architectural PC
//   sel          - one-hot next-PC source from the control unit
//   cmp_zero     - ALU result is zero (beq/bne)
//   cmp_lt       - ALU less-than bit (blt/bge family)
//   br_target    - pc + imm
//   jalr_target  - rs1 + imm
//   npc          - selected, word-aligned next PC
//   err          - sel not one-hot, or selected target misaligned
module ysyx_22040088_nextpc
  import ysyx_22040088_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [SEL_W-1:0] sel,
  input  logic             cmp_zero,
  input  logic             cmp_lt,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  jalr_target,
  output logic [XLEN-1:0]  npc,
  output logic             err
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] raw_npc;
  logic            one_hot;

  always_comb begin
    seq_pc  = pc + XLEN'(4);
    one_hot = $onehot(sel);
    raw_npc = seq_pc;
    // Guarded so the unique decode only ever sees a legal one-hot vector.
    if (one_hot) begin
      unique case (1'b1)
        sel[SEL_SEQ]:  raw_npc = seq_pc;
        sel[SEL_JAL]:  raw_npc = br_target;
        sel[SEL_JALR]: raw_npc = {jalr_target[XLEN-1:1], 1'b0};
        sel[SEL_BEQ]:  raw_npc = cmp_zero ? br_target : seq_pc;
        sel[SEL_BNE]:  raw_npc = !cmp_zero ? br_target : seq_pc;
        sel[SEL_BLT]:  raw_npc = cmp_lt ? br_target : seq_pc;
        sel[SEL_BGE]:  raw_npc = !cmp_lt ? br_target : seq_pc;
        default:       raw_npc = seq_pc;
      endcase
    end

    err = 1'b0;
    npc = raw_npc;
    if (!one_hot) begin
      err = 1'b1;
      npc = seq_pc;
    end else if (raw_npc[1:0] != 2'b00) begin
      err = 1'b1;
      npc = {raw_npc[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per step over a
// valid/ready request + valid response memory port, hands it to decode, then
// waits for execute to resolve the next PC.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr - fetch request (addr is the PC)
//   imem_resp_valid/data      - fetch response, sampled only while waiting
//   inst_valid/ready, inst, inst_pc - registered instruction towards decode
//   next_valid, sel_nextpc, cmp_zero, cmp_lt, br_target, jalr_target - next-PC inputs
//   nextpc_err                - pulse on an illegal select or misaligned target
module ysyx_22040088_ifu
  import ysyx_22040088_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_resp_valid,
  input  logic [31:0]      imem_resp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             next_valid,
  input  logic [SEL_W-1:0] sel_nextpc,
  input  logic             cmp_zero,
  input  logic             cmp_lt,
  input  logic [XLEN-1:0]  br_target,
  input  logic [XLEN-1:0]  jalr_target,
  output logic             nextpc_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] npc;
  logic            npc_err;

  ysyx_22040088_nextpc #(
    .XLEN(XLEN)
  ) u_nextpc (
    .pc          (pc_q),
    .sel         (sel_nextpc),
    .cmp_zero    (cmp_zero),
    .cmp_lt      (cmp_lt),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .npc         (npc),
    .err         (npc_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    nextpc_err     = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (imem_resp_valid) begin
          inst_d    = imem_resp_data;
          inst_pc_d = pc_q;
          state_d   = StHold;
        end
      end
      StHold: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = StExec;
      end
      StExec: begin
        if (next_valid) begin
          pc_d       = npc;
          nextpc_err = npc_err;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_addr = pc_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
module tb_ysyx_22040088_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        next_valid = 1'b0;
  logic [6:0]  sel_nextpc = 7'b0;
  logic        cmp_zero = 1'b0;
  logic        cmp_lt = 1'b0;
  logic [63:0] br_target = 64'h0;
  logic [63:0] jalr_target = 64'h0;
  logic        nextpc_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040088_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .next_valid      (next_valid),
    .sel_nextpc      (sel_nextpc),
    .cmp_zero        (cmp_zero),
    .cmp_lt          (cmp_lt),
    .br_target       (br_target),
    .jalr_target     (jalr_target),
    .nextpc_err      (nextpc_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, answer after one cycle,
  // check the presented instruction, and leave the DUT in EXEC at a negedge.
  task automatic fetch(input logic [63:0] exp_addr, input logic [31:0] data);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", 64'(imem_req_valid), 64'd1);
    check("imem_addr", imem_addr, exp_addr);
    @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check("inst_valid", 64'(inst_valid), 64'd1);
    check("inst", 64'(inst), 64'(data));
    check("inst_pc", inst_pc, exp_addr);
    @(negedge clk);
  endtask

  task automatic exec_next(input logic [6:0] sel, input logic cz, input logic clt,
                           input logic [63:0] bt, input logic [63:0] jt, input logic exp_err);
    sel_nextpc  = sel;
    cmp_zero    = cz;
    cmp_lt      = clt;
    br_target   = bt;
    jalr_target = jt;
    next_valid  = 1'b1;
    #1;
    check("nextpc_err", 64'(nextpc_err), 64'(exp_err));
    @(negedge clk);
    next_valid = 1'b0;
    sel_nextpc = 7'b0;
    check("err_pulse_end", 64'(nextpc_err), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'h13);
    check("rst_inst_pc", inst_pc, 64'h8000_0000);
    check("rst_addr", imem_addr, 64'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'd1);

    // Sequential, wrap and branches
    fetch(64'h8000_0000, 32'h0000_0093);
    exec_next(7'b0000001, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    fetch(64'h8000_0004, 32'h1111_1111);
    exec_next(7'b0000010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h2222_2222);
    exec_next(7'b0000001, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    fetch(64'h0, 32'h3333_3333);
    exec_next(7'b0001000, 1'b1, 1'b0, 64'h8000_0100, 64'h0, 1'b0);
    fetch(64'h8000_0100, 32'h4444_4444);
    exec_next(7'b0010000, 1'b1, 1'b0, 64'h8000_0100, 64'h0, 1'b0);
    fetch(64'h8000_0104, 32'h5555_5555);
    exec_next(7'b1000000, 1'b0, 1'b0, 64'h8000_0100, 64'h0, 1'b0);
    fetch(64'h8000_0100, 32'h6666_6666);
    exec_next(7'b0100000, 1'b0, 1'b0, 64'h8000_0100, 64'h0, 1'b0);

    // Stalls at 0x8000_0104: request held off, slow response, decode stall
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("stall_req_valid", 64'(imem_req_valid), 64'd1);
      check("stall_addr", imem_addr, 64'h8000_0104);
      @(negedge clk);
    end
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("wait_no_refetch", 64'(imem_req_valid), 64'd0);
      check("wait_inst_valid", 64'(inst_valid), 64'd0);
      check("wait_inst", 64'(inst), 64'h6666_6666);
      @(negedge clk);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h7777_7777;
    inst_ready      = 1'b0;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_inst_valid", 64'(inst_valid), 64'd1);
      check("hold_inst", 64'(inst), 64'h7777_7777);
      check("hold_inst_pc", inst_pc, 64'h8000_0104);
      @(negedge clk);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    // In EXEC: stray response and no next_valid yet
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    @(negedge clk);
    check("exec_stray_inst", 64'(inst), 64'h7777_7777);
    check("exec_no_req", 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b0;

    // Misaligned jalr, then illegal select
    exec_next(7'b0000100, 1'b0, 1'b0, 64'h0, 64'h8000_0203, 1'b1);
    fetch(64'h8000_0200, 32'h8888_8888);
    exec_next(7'b0000110, 1'b0, 1'b0, 64'h1234_0000, 64'h0, 1'b1);
    fetch(64'h8000_0204, 32'h9999_9999);
    exec_next(7'b0000000, 1'b0, 1'b0, 64'h1234_0000, 64'h0, 1'b1);

    // Reset in the middle of WAIT
    check("pre_rst_addr", imem_addr, 64'h8000_0208);
    @(negedge clk);
    check("in_wait", 64'(imem_req_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("async_rst_addr", imem_addr, 64'h8000_0000);
    check("async_rst_inst", 64'(inst), 64'h13);
    check("async_rst_inst_pc", inst_pc, 64'h8000_0000);
    check("async_rst_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFE_CAFE;
    @(negedge clk);
    check("restart_req", 64'(imem_req_valid), 64'd1);
    check("late_resp_ignored", 64'(inst), 64'h13);
    imem_resp_valid = 1'b0;
    fetch(64'h8000_0000, 32'h0000_0113);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule
